// File: rtl/comp_cic_seq.sv
// rtl/comp_cic_seq.sv - CIC compensation FIR sequencer: delay line, MAC control, round/saturate output
module comp_cic_seq #(
  parameter int Win    = 16,
  parameter int Wcoef  = 18,
  parameter int Waccum = 34,
  parameter int Wout   = 16,
  parameter int NTAPS  = 16,
  parameter int SHIFT  = 17,
  parameter int Waddr  = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              ic_rst,
  input  logic [Win-1:0]    id_in,
  input  logic              ic_val_in,
  output logic              oc_ready,
  output logic [Win-1:0]    od_reg_desp,
  output logic [Waddr-1:0]  od_coef_addr,
  output logic              oc_en_acc,
  output logic              oc_rst_acc,
  input  logic [Waccum-1:0] id_acc,
  output logic [Wout-1:0]   od_out,
  output logic              oc_val_out,
  output logic              od_ovr
);

  if (Win + Wcoef > Waccum + 1) begin : g_width_chk
    $error("accumulator too narrow for sample x coefficient product");
  end

  typedef enum logic [2:0] {IDLE, CLR, MAC, FLUSH, OUT} state_t;

  localparam logic [Waddr-1:0] LAST = Waddr'(NTAPS - 1);
  localparam logic signed [Waccum:0] RND =
    {{(Waccum + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
  localparam logic signed [Waccum:0] OMAX =
    {{(Waccum + 2 - Wout){1'b0}}, {(Wout - 1){1'b1}}};
  localparam logic signed [Waccum:0] OMIN =
    {{(Waccum + 2 - Wout){1'b1}}, {(Wout - 1){1'b0}}};

  state_t           state_q;
  logic [Win-1:0]   dline_q [NTAPS];
  logic [Waddr-1:0] wptr_q, rptr_q, k_q, addr_q;
  logic [Win-1:0]   desp_q;
  logic [Wout-1:0]  out_q;
  logic             ready_q, en_q, rst_acc_q, val_q, ovr_q;

  logic signed [Waccum:0] rnd_d, shf_d;
  logic [Wout-1:0]        sat_d;

  // Sign-extend by one bit first so the rounding add cannot wrap.
  always_comb begin
    rnd_d = $signed({id_acc[Waccum-1], id_acc}) + RND;
    shf_d = rnd_d >>> SHIFT;
    if (shf_d > OMAX)      sat_d = OMAX[Wout-1:0];
    else if (shf_d < OMIN) sat_d = OMIN[Wout-1:0];
    else                   sat_d = shf_d[Wout-1:0];
  end

  always_ff @(posedge clk or posedge ic_rst) begin
    if (ic_rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < NTAPS; i++) dline_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      k_q       <= '0;
      addr_q    <= '0;
      desp_q    <= '0;
      out_q     <= '0;
      ready_q   <= 1'b1;
      en_q      <= 1'b0;
      rst_acc_q <= 1'b0;
      val_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      val_q <= 1'b0;
      if (ic_val_in && !ready_q) ovr_q <= 1'b1;
      case (state_q)
        IDLE, OUT: begin
          if (ic_val_in) begin
            dline_q[wptr_q] <= id_in;
            rptr_q    <= wptr_q;
            wptr_q    <= (wptr_q == LAST) ? '0 : wptr_q + Waddr'(1);
            addr_q    <= '0;
            rst_acc_q <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= CLR;
          end else begin
            state_q   <= IDLE;
          end
        end
        CLR: begin
          rst_acc_q <= 1'b0;
          en_q      <= 1'b1;
          desp_q    <= dline_q[rptr_q];
          rptr_q    <= (rptr_q == '0) ? LAST : rptr_q - Waddr'(1);
          addr_q    <= Waddr'(1);
          k_q       <= '0;
          state_q   <= MAC;
        end
        MAC: begin
          // Address runs one tap ahead of the operand to cover the ROM read latency.
          if (k_q == LAST) begin
            en_q    <= 1'b0;
            state_q <= FLUSH;
          end else begin
            desp_q <= dline_q[rptr_q];
            rptr_q <= (rptr_q == '0) ? LAST : rptr_q - Waddr'(1);
            k_q    <= k_q + Waddr'(1);
            if (int'(k_q) + 2 < NTAPS) addr_q <= Waddr'(int'(k_q) + 2);
          end
        end
        FLUSH: begin
          out_q   <= sat_d;
          val_q   <= 1'b1;
          ready_q <= 1'b1;
          state_q <= OUT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oc_ready     = ready_q;
  assign od_reg_desp  = desp_q;
  assign od_coef_addr = addr_q;
  assign oc_en_acc    = en_q;
  assign oc_rst_acc   = rst_acc_q;
  assign od_out       = out_q;
  assign oc_val_out   = val_q;
  assign od_ovr       = ovr_q;

endmodule
